// File: rtl/kf_mul_arbiter_pkg.sv
// rtl/kf_mul_arbiter_pkg.sv - shared fixed-point constants and index helper for the KF multiplier arbiter
// Purpose: fixed-point format defaults, multiplier lane count and a small
//          modulo helper used by the round-robin search.
// Ports:   none (package).
package kf_mul_arbiter_pkg;

   localparam int FXP_N     = 16;  // operand width
   localparam int FXP_FRAC  = 8;   // fraction bits of the Q format
   localparam int FXP_LANES = 4;   // multipliers in the shared bank

   // Wraps an index that is known to be below 2*n back into 0..n-1.
   function automatic int wrap_idx(input int idx, input int n);
      return (idx >= n) ? idx - n : idx;
   endfunction

endpackage

// File: rtl/fxp_mul.sv
// rtl/fxp_mul.sv - signed full-precision fixed-point multiplier lane
// Purpose: one N x N -> 2N signed product; the binary point of p sits at
//          2*FRAC, and any rescaling is left to the consumer.
// Ports:   a, b  in  N   signed operands
//          p     out 2N  signed full-precision product
module fxp_mul
   import kf_mul_arbiter_pkg::*;
#(
   parameter int N    = FXP_N,
   parameter int FRAC = FXP_FRAC
) (
   input  logic signed [N-1:0]   a,
   input  logic signed [N-1:0]   b,
   output logic signed [2*N-1:0] p
);

   // A Q format with more fraction bits than the word is meaningless.
   if (FRAC < 0 || FRAC >= N) begin : g_frac_range
      $error("fxp_mul: FRAC must lie in 0..N-1");
   end

   assign p = a * b;

endmodule

// File: rtl/kf_mul_arbiter_rr_lock_arb.sv
// rtl/kf_mul_arbiter_rr_lock_arb.sv - round-robin arbiter with bounded lock ownership
// Purpose: picks at most one requester per cycle; a locked owner keeps the
//          grant for up to MAXHOLD consecutive cycles before round-robin
//          resumes from the requester after the owner.
// Ports:   clk, rst_n  in  clock, async active-low reset
//          req, lock   in  NREQ  per-requester request / keep-grant request
//          gnt         out NREQ  one-hot grant (combinational)
//          gnt_id      out IDW   index of the granted requester (valid when |gnt)
module rr_lock_arb
   import kf_mul_arbiter_pkg::*;
#(
   parameter int NREQ    = 3,
   parameter int MAXHOLD = 8,
   localparam int IDW    = $clog2(NREQ),
   localparam int HW     = $clog2(MAXHOLD + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] lock,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_id
);

   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW-1:0] owner_q, owner_d;
   logic           owner_valid_q, owner_valid_d;
   logic [HW-1:0]  hold_cnt_q, hold_cnt_d;

   logic           found;
   logic           at_limit;
   logic [IDW-1:0] start;
   int             idx;

   always_comb begin
      gnt      = '0;
      gnt_id   = '0;
      found    = 1'b0;
      start    = ptr_q;
      idx      = 0;
      at_limit = (hold_cnt_q == HW'(MAXHOLD));

      if (owner_valid_q && req[owner_q] && !at_limit) begin
         found  = 1'b1;
         gnt_id = owner_q;
      end else begin
         // An exhausted owner that still requests yields to the next index;
         // the search wraps back to it when nobody else is pending.
         if (owner_valid_q && req[owner_q] && at_limit)
            start = IDW'(wrap_idx(int'(owner_q) + 1, NREQ));
         for (int off = 0; off < NREQ; off++) begin
            idx = wrap_idx(int'(start) + off, NREQ);
            if (!found && req[idx]) begin
               found  = 1'b1;
               gnt_id = IDW'(idx);
            end
         end
      end

      if (found)
         gnt[gnt_id] = 1'b1;

      ptr_d         = ptr_q;
      owner_d       = owner_q;
      owner_valid_d = owner_valid_q;
      hold_cnt_d    = hold_cnt_q;

      if (!found) begin
         owner_valid_d = 1'b0;
         hold_cnt_d    = '0;
      end else if (lock[gnt_id]) begin
         owner_d       = gnt_id;
         owner_valid_d = 1'b1;
         // Counting continues only for an uninterrupted run by the same owner.
         if (owner_valid_q && (owner_q == gnt_id) && !at_limit)
            hold_cnt_d = hold_cnt_q + HW'(1);
         else
            hold_cnt_d = HW'(1);
      end else begin
         owner_valid_d = 1'b0;
         hold_cnt_d    = '0;
         ptr_d         = IDW'(wrap_idx(int'(gnt_id) + 1, NREQ));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q         <= '0;
         owner_q       <= '0;
         owner_valid_q <= 1'b0;
         hold_cnt_q    <= '0;
      end else begin
         ptr_q         <= ptr_d;
         owner_q       <= owner_d;
         owner_valid_q <= owner_valid_d;
         hold_cnt_q    <= hold_cnt_d;
      end
   end

endmodule

// File: rtl/kf_mul_arbiter.sv
// rtl/kf_mul_arbiter.sv - shares four fixed-point multipliers among KF stage engines
// Purpose: arbitrates NREQ engines, latches the winner's four operand pairs
//          and returns the four full-precision products one cycle later.
// Ports:   clk, rst_n   in  clock, async active-low reset
//          req, lock    in  NREQ        request / keep-grant per engine
//          op_a, op_b   in  NREQ*4*N    operands, engine i lane k at [(4i+k)*N +: N]
//          gnt          out NREQ        one-hot grant, same cycle as req
//          res_valid    out 1           products valid (registered)
//          res_id       out clog2(NREQ) owner of the products
//          res_full     out 4*2N        lane k product at [k*2N +: 2N]
//          busy         out 1           a grant is issued this cycle
module kf_mul_arbiter
   import kf_mul_arbiter_pkg::*;
#(
   parameter int N       = FXP_N,
   parameter int FRAC    = FXP_FRAC,
   parameter int NREQ    = 3,
   parameter int MAXHOLD = 8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NREQ-1:0]                 req,
   input  logic [NREQ-1:0]                 lock,
   input  logic [NREQ*FXP_LANES*N-1:0]     op_a,
   input  logic [NREQ*FXP_LANES*N-1:0]     op_b,
   output logic [NREQ-1:0]                 gnt,
   output logic                            res_valid,
   output logic [$clog2(NREQ)-1:0]         res_id,
   output logic [FXP_LANES*2*N-1:0]        res_full,
   output logic                            busy
);

   localparam int IDW = $clog2(NREQ);
   localparam int LW  = FXP_LANES * N;

   logic [IDW-1:0] gnt_id;
   logic [LW-1:0]  a_q, a_d, b_q, b_d;
   logic [IDW-1:0] id_q, id_d;
   logic           valid_q, valid_d;

   rr_lock_arb #(
      .NREQ    (NREQ),
      .MAXHOLD (MAXHOLD)
   ) u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .lock   (lock),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   assign busy = |gnt;

   // Operand registers hold when nobody is granted so res_full stays stable.
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      id_d    = id_q;
      valid_d = busy;
      if (busy) begin
         a_d  = op_a[int'(gnt_id)*LW +: LW];
         b_d  = op_b[int'(gnt_id)*LW +: LW];
         id_d = gnt_id;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         id_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         id_q    <= id_d;
         valid_q <= valid_d;
      end
   end

   for (genvar k = 0; k < FXP_LANES; k++) begin : g_lane
      fxp_mul #(
         .N    (N),
         .FRAC (FRAC)
      ) u_mul (
         .a (a_q[k*N +: N]),
         .b (b_q[k*N +: N]),
         .p (res_full[k*2*N +: 2*N])
      );
   end

   assign res_valid = valid_q;
   assign res_id    = id_q;

endmodule

// File: tb/tb_kf_mul_arbiter.sv
// tb/tb_kf_mul_arbiter.sv - scoreboard bench for kf_mul_arbiter
module tb_kf_mul_arbiter;

   logic         clk;
   logic         rst_n;
   logic [2:0]   req;
   logic [2:0]   lock;
   logic [191:0] op_a;
   logic [191:0] op_b;
   logic [2:0]   gnt;
   logic         res_valid;
   logic [1:0]   res_id;
   logic [127:0] res_full;
   logic         busy;

   typedef struct {
      logic [1:0]   id;
      logic [127:0] full;
   } exp_t;

   exp_t sb_q[$];
   int   tests = 0;
   int   fails = 0;

   logic signed [15:0] ta[3][4];
   logic signed [15:0] tb[3][4];

   localparam logic [127:0] HAND_EXP =
      {32'h4000_0000, 32'h3FFF_0001, 32'hFFFD_8000, 32'h0003_0000};

   kf_mul_arbiter #(
      .N       (16),
      .FRAC    (8),
      .NREQ    (3),
      .MAXHOLD (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .lock      (lock),
      .op_a      (op_a),
      .op_b      (op_b),
      .gnt       (gnt),
      .res_valid (res_valid),
      .res_id    (res_id),
      .res_full  (res_full),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   function automatic void set_ops(input int s);
      for (int i = 0; i < 3; i++)
         for (int k = 0; k < 4; k++) begin
            ta[i][k] = 16'(s * 1031 + i * 4099 + k * 257 - 20000);
            tb[i][k] = 16'(s * 577 - i * 3001 + k * 911 + 123);
         end
   endfunction

   function automatic void pack_ops();
      for (int i = 0; i < 3; i++)
         for (int k = 0; k < 4; k++) begin
            op_a[(4*i+k)*16 +: 16] = ta[i][k];
            op_b[(4*i+k)*16 +: 16] = tb[i][k];
         end
   endfunction

   // Drives one cycle at posedge+1, checks the combinational grant and
   // queues the expected products for the monitor.
   task automatic step(input logic [2:0] r, input logic [2:0] l, input logic [2:0] eg,
                       input string nm, input bit hand);
      exp_t              e;
      logic signed [31:0] p;
      req  = r;
      lock = l;
      pack_ops();
      #1;
      check({nm, "_gnt"}, 128'(gnt), 128'(eg));
      check({nm, "_busy"}, 128'(busy), 128'(eg != 3'b000));
      if (eg != 3'b000) begin
         e.id = (eg == 3'b010) ? 2'd1 : (eg == 3'b100) ? 2'd2 : 2'd0;
         if (hand) begin
            e.full = HAND_EXP;
         end else begin
            for (int k = 0; k < 4; k++) begin
               p = ta[e.id][k] * tb[e.id][k];
               e.full[k*32 +: 32] = p;
            end
         end
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (res_valid) begin
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result: got res_valid=1 id=%0d expected no result", res_id);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("result_id", 128'(res_id), 128'(e.id));
            check("result_full", res_full, e.full);
         end
      end
   end

   initial begin
      clk   = 1'b0;
      rst_n = 1'b0;
      req   = '0;
      lock  = '0;
      op_a  = '0;
      op_b  = '0;
      set_ops(0);

      repeat (3) @(posedge clk);
      #1;
      check("reset_gnt", 128'(gnt), 128'(0));
      check("reset_res_valid", 128'(res_valid), 128'(0));
      check("reset_res_full", res_full, 128'(0));
      check("reset_res_id", 128'(res_id), 128'(0));
      check("reset_busy", 128'(busy), 128'(0));
      rst_n = 1'b1;

      // plain round-robin
      for (int c = 0; c < 6; c++) begin
         set_ops(c + 1);
         step(3'b111, 3'b000, 3'(1 << (c % 3)), "rr", 1'b0);
      end

      // single request with hand-computed Q8 products
      set_ops(7);
      ta[0][0] = 16'sh0180; tb[0][0] = 16'sh0200;  //  1.5  * 2.0
      ta[0][1] = -16'sh0140; tb[0][1] = 16'sh0200; // -1.25 * 2.0
      ta[0][2] = 16'sh7FFF; tb[0][2] = 16'sh7FFF;
      ta[0][3] = -16'sh8000; tb[0][3] = -16'sh8000;
      step(3'b001, 3'b000, 3'b001, "single", 1'b1);

      step(3'b000, 3'b000, 3'b000, "idle", 1'b0);
      set_ops(8);
      step(3'b100, 3'b000, 3'b100, "to2", 1'b0);

      // lock with hold limit 8
      for (int c = 0; c < 8; c++) begin
         set_ops(10 + c);
         step(3'b011, 3'b001, 3'b001, "lock_hold", 1'b0);
      end
      set_ops(20);
      step(3'b011, 3'b001, 3'b010, "lock_limit", 1'b0);
      step(3'b011, 3'b001, 3'b001, "lock_regain", 1'b0);
      set_ops(21);
      step(3'b011, 3'b001, 3'b001, "lock_regain2", 1'b0);
      step(3'b010, 3'b001, 3'b010, "lock_release", 1'b0);

      // lone locked owner keeps getting re-granted past the limit
      for (int c = 0; c < 10; c++) begin
         set_ops(30 + c);
         step(3'b001, 3'b001, 3'b001, "solo_lock", 1'b0);
      end

      // burst then asynchronous reset with a result in flight
      set_ops(41);
      step(3'b111, 3'b000, 3'b001, "burst_owner", 1'b0);
      set_ops(42);
      step(3'b111, 3'b000, 3'b010, "burst", 1'b0);
      rst_n = 1'b0;
      #1;
      check("midreset_res_valid", 128'(res_valid), 128'(0));
      check("midreset_res_full", res_full, 128'(0));
      check("midreset_res_id", 128'(res_id), 128'(0));
      sb_q.delete();
      req  = '0;
      lock = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("postreset_gnt", 128'(gnt), 128'(0));
      set_ops(50);
      step(3'b111, 3'b000, 3'b001, "post_reset", 1'b0);
      step(3'b000, 3'b000, 3'b000, "post_idle", 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", 128'(sb_q.size()), 128'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
